// File: rtl/single_instruction_pkg.sv
// rtl/single_instruction_pkg.sv - opcode/funct3 constants, ALU operation enum and ALU-op decode helper
package single_instruction_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B
    } alu_op_e;

    // alt is instruction[30]. It selects SUB only for register-register ops,
    // because in OP-IMM bit 30 is part of the immediate for ADDI.
    function automatic alu_op_e decode_alu_op(input logic [2:0] f3,
                                              input logic       alt,
                                              input logic       is_imm);
        alu_op_e op;
        op = ALU_ADD;
        case (f3)
            F3_ADD:  op = (alt && !is_imm) ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/single_instruction_core_reg_mem.sv
// rtl/single_instruction_core_reg_mem.sv - 32x32 register file, 2 combinational reads, 1 write
// Ports: clk, rst (sync, active-high, clears all registers),
//        raddr1/raddr2 -> rdata1/rdata2 (combinational, x0 reads 0),
//        we/waddr/wdata (write on rising edge, writes to x0 dropped).
module reg_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] memory [0:31];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                memory[i] <= 32'd0;
            end
        end else if (we && (waddr != 5'd0)) begin
            memory[waddr] <= wdata;
        end
    end

    // Reads see the pre-edge contents, so a read of the register being
    // written returns its old value until the edge.
    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : memory[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : memory[raddr2];

endmodule

// File: rtl/single_instruction_core.sv
// rtl/single_instruction_core.sv - single-cycle RV32I OP/OP-IMM/LUI execute slice
// Ports: clk, rst (sync, active-high), instruction[31:0] (executed every edge).
// No outputs; architectural state lives in reg_mem.memory[0:31].
module single_instruction_core
    import single_instruction_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction
);

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm_i;
    logic [31:0] imm_u;

    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic        wr_en;
    alu_op_e     alu_op;
    logic [31:0] alu_res;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign imm_i  = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_u  = {instruction[31:12], 12'd0};

    always_comb begin
        wr_en  = 1'b0;
        alu_op = ALU_ADD;
        op_b   = imm_i;
        case (opcode)
            OPC_OP_IMM: begin
                wr_en  = 1'b1;
                op_b   = imm_i;
                alu_op = decode_alu_op(funct3, instruction[30], 1'b1);
            end
            OPC_OP: begin
                wr_en  = 1'b1;
                op_b   = rs2_val;
                alu_op = decode_alu_op(funct3, instruction[30], 1'b0);
            end
            OPC_LUI: begin
                wr_en  = 1'b1;
                op_b   = imm_u;
                alu_op = ALU_PASS_B;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    // imm_i[4:0] equals instruction[24:20], so one source covers both
    // immediate and register shift amounts.
    assign shamt = op_b[4:0];

    always_comb begin
        alu_res = 32'd0;
        case (alu_op)
            ALU_ADD:    alu_res = rs1_val + op_b;
            ALU_SUB:    alu_res = rs1_val - op_b;
            ALU_SLL:    alu_res = rs1_val << shamt;
            ALU_SLT:    alu_res = {31'd0, $signed(rs1_val) < $signed(op_b)};
            ALU_SLTU:   alu_res = {31'd0, rs1_val < op_b};
            ALU_XOR:    alu_res = rs1_val ^ op_b;
            ALU_SRL:    alu_res = rs1_val >> shamt;
            ALU_SRA:    alu_res = $unsigned($signed(rs1_val) >>> shamt);
            ALU_OR:     alu_res = rs1_val | op_b;
            ALU_AND:    alu_res = rs1_val & op_b;
            ALU_PASS_B: alu_res = op_b;
            default:    alu_res = 32'd0;
        endcase
    end

    reg_mem reg_mem (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val),
        .we     (wr_en),
        .waddr  (rd),
        .wdata  (alu_res)
    );

endmodule

// File: tb/tb_single_instruction_core.sv
// tb/tb_single_instruction_core.sv - scoreboard bench for single_instruction_core
module tb_single_instruction_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction = 32'd0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          idx;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];

    single_instruction_core dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%08h want=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] u_lui(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'b0110111};
    endfunction

    task automatic push_exp(input int idx, input logic [31:0] val, input string tag);
        exp_t e;
        e.idx = idx;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // One rising edge, then drain every expectation queued for it.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, dut.reg_mem.memory[e.idx], e.val);
        end
    endtask

    task automatic exec(input logic [31:0] instr, input int rd, input logic [31:0] val,
                        input string tag);
        instruction = instr;
        push_exp(rd, val, tag);
        step();
    endtask

    initial begin
        // reset clears the whole file
        rst = 1'b1;
        instruction = 32'd0;
        for (int i = 0; i < 32; i++) push_exp(i, 32'd0, $sformatf("rst_x%0d", i));
        step();
        rst = 1'b0;

        check_eq("pre_x5_not12", {31'd0, dut.reg_mem.memory[5] != 32'd12}, 32'd1);
        exec(i_type(12'd12, 5'd0, 3'b000, 5'd5), 5, 32'd12, "addi_x5_12");
        exec(i_type(12'd20, 5'd0, 3'b000, 5'd5), 5, 32'd20, "addi_x5_20");

        // reset has priority over a pending instruction
        rst = 1'b1;
        instruction = i_type(12'd7, 5'd0, 3'b000, 5'd5);
        push_exp(5, 32'd0, "rst_drop_x5");
        push_exp(0, 32'd0, "rst_drop_x0");
        step();
        rst = 1'b0;

        // held instruction re-executes each edge
        exec(i_type(12'd1, 5'd5, 3'b000, 5'd5), 5, 32'd1, "hold_inc1");
        exec(i_type(12'd1, 5'd5, 3'b000, 5'd5), 5, 32'd2, "hold_inc2");

        // signed arithmetic
        exec(i_type(12'd5, 5'd0, 3'b000, 5'd1), 1, 32'd5, "addi_x1_5");
        exec(r_type(7'b0100000, 5'd1, 5'd0, 3'b000, 5'd2), 2, 32'hFFFF_FFFB, "sub");
        exec(i_type(12'h401, 5'd2, 3'b101, 5'd3), 3, 32'hFFFF_FFFD, "srai");
        exec(i_type(12'd28, 5'd2, 3'b101, 5'd4), 4, 32'h0000_000F, "srli");

        // compares
        exec(i_type(12'hFFF, 5'd0, 3'b000, 5'd1), 1, 32'hFFFF_FFFF, "addi_m1");
        exec(r_type(7'd0, 5'd0, 5'd1, 3'b010, 5'd2), 2, 32'd1, "slt");
        exec(r_type(7'd0, 5'd0, 5'd1, 3'b011, 5'd3), 3, 32'd0, "sltu");
        exec(i_type(12'hFFF, 5'd0, 3'b011, 5'd4), 4, 32'd1, "sltiu");
        exec(i_type(12'd0, 5'd1, 3'b010, 5'd5), 5, 32'd1, "slti");

        // x0, NOP, LUI
        exec(i_type(12'd99, 5'd0, 3'b000, 5'd0), 0, 32'd0, "x0_write");
        exec({25'h0, 5'd5, 7'b1111111}, 5, 32'd1, "nop_x5");
        exec(u_lui(20'hABCDE, 5'd6), 6, 32'hABCD_E000, "lui");

        // logic and shifts
        exec(i_type(12'h0F0, 5'd0, 3'b000, 5'd1), 1, 32'h0000_00F0, "addi_f0");
        exec(i_type(12'h0FF, 5'd1, 3'b100, 5'd2), 2, 32'h0000_000F, "xori");
        exec(i_type(12'h00F, 5'd1, 3'b110, 5'd3), 3, 32'h0000_00FF, "ori");
        exec(i_type(12'h00F, 5'd1, 3'b111, 5'd4), 4, 32'h0000_0000, "andi");
        exec(i_type(12'd4, 5'd1, 3'b001, 5'd3), 3, 32'h0000_0F00, "slli");

        // register-register forms
        exec(i_type(12'd4, 5'd0, 3'b000, 5'd7), 7, 32'd4, "addi_x7");
        exec(r_type(7'd0, 5'd7, 5'd1, 3'b001, 5'd8), 8, 32'h0000_0F00, "sll");
        exec(r_type(7'b0100000, 5'd1, 5'd0, 3'b000, 5'd10), 10, 32'hFFFF_FF10, "sub_neg");
        exec(r_type(7'b0100000, 5'd7, 5'd10, 3'b101, 5'd11), 11, 32'hFFFF_FFF1, "sra");
        exec(r_type(7'd0, 5'd7, 5'd10, 3'b101, 5'd12), 12, 32'h0FFF_FFF1, "srl");
        exec(r_type(7'd0, 5'd7, 5'd1, 3'b000, 5'd13), 13, 32'h0000_00F4, "add");
        exec(r_type(7'd0, 5'd2, 5'd1, 3'b100, 5'd14), 14, 32'h0000_00FF, "xor");
        exec(r_type(7'd0, 5'd7, 5'd1, 3'b110, 5'd15), 15, 32'h0000_00F4, "or");
        exec(r_type(7'd0, 5'd2, 5'd1, 3'b111, 5'd16), 16, 32'h0000_0000, "and");
        exec(i_type(12'd36, 5'd0, 3'b000, 5'd17), 17, 32'd36, "addi_36");
        exec(r_type(7'd0, 5'd17, 5'd1, 3'b101, 5'd18), 18, 32'h0000_000F, "srl_shamt5");

        // earlier results untouched
        check_eq("keep_x6", dut.reg_mem.memory[6], 32'hABCD_E000);
        check_eq("keep_x5", dut.reg_mem.memory[5], 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/single_instruction_core.md
# single_instruction_core

Single-cycle RV32I integer execute slice. It decodes one externally supplied 32-bit instruction per clock, reads operands from a 32×32 register file, computes the result combinationally, and writes it back to `rd` on the rising clock edge. It is the datapath core with no program counter or memory. It is used standalone in unit benches and later wrapped by a fetch stage.

## Interface
- No parameters. XLEN is fixed at 32 and there are 32 registers.
- `clk`  in  1  Sole clock. All state updates on the rising edge.
- `rst`  in  1  Reset is synchronous and active-high.
- `instruction`  in  32  RV32I instruction word. It must be stable and valid before each rising edge of `clk`.
- No outputs. Architectural state is observed hierarchically at `reg_mem.memory[0:31]`; this array name and path are fixed.

## Operation
- Decode fields:
  - `opcode=[6:0]`, `rd=[11:7]`, `funct3=[14:12]`, `rs1=[19:15]`, `rs2=[24:20]`, `funct7=[31:25]`.
  - I-immediate is `[31:20]`, sign-extended to 32 bits.
  - U-immediate is `{[31:12], 12'b0}`.
- OP-IMM (`0010011`), selected by funct3:
  - 000 ADDI, 010 SLTI, 011 SLTIU, 100 XORI, 110 ORI, 111 ANDI.
  - 001 SLLI.
  - 101 SRLI when `instruction[30]=0`, SRAI when `instruction[30]=1`.
  - Shift amount is `[24:20]`. All other funct7 bits are ignored.
- OP (`0110011`), selected by funct3:
  - 000 ADD, or SUB when bit30=1.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
  - 101 SRL, or SRA when bit30=1.
  - 110 OR, 111 AND.
  - Shift amount is `rs2_val[4:0]`. funct7 bits other than bit30 are ignored.
- LUI (`0110111`): `rd ← U-immediate`.
- Any other opcode is a NOP: no register write occurs and no error is flagged.
- Arithmetic:
  - Add and subtract wrap modulo 2^32.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned. For SLTIU the immediate is sign-extended first, then compared unsigned.
  - The result of a compare is 0 or 1, zero-extended.
  - SRA/SRAI replicate bit 31.
- Register file:
  - Two combinational read ports (`rs1`, `rs2`) and one write port.
  - x0 always reads 0. Writes with `rd=0` are discarded.
  - A read of the same register being written returns the old value until the edge.

## Timing
- Latency is one cycle: the result is visible in `memory[rd]` immediately after the rising edge that samples the instruction.
- Exactly one write occurs per rising edge for each valid non-NOP instruction. The same instruction held across several edges re-executes each edge.
  - This is idempotent for LUI, ADDI with `rs1=x0`, and similar.
  - It is cumulative for `ADDI x5,x5,1`.
- Reset:
  - When `rst=1` at a rising edge, all 32 registers are set to 0 and the instruction is not executed. Reset has priority.
  - Reset asserted mid-sequence discards that cycle's write.
  - After reset, the first execution occurs on the first edge with `rst=0`.
- Before any reset or edge, register contents are unspecified and must not equal a written value until a clock edge occurs.
- There is no handshake and no stall.

## Structure
- Package `single_instruction_pkg` holds:
  - Opcode constants (OP_IMM, OP, LUI).
  - funct3 constants.
  - The ALU-operation enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B).
- Sub-module `reg_mem`:
  - Instance name is `reg_mem`.
  - Contains `reg [31:0] memory [0:31]`, 2R/1W.
  - Has a synchronous reset and discards writes to x0.
- The decoder, immediate generator and ALU are combinational logic in the top level.

## Test plan
- Load x5: `ADDI x5,x0,12`, one edge → `memory[5]=12`. Before that edge `memory[5]≠12`. Then `ADDI x5,x0,20`, one edge → `memory[5]=20`.
- Reset: with x5=20, `rst=1` for one edge → all registers are 0. Apply `ADDI x5,x0,7` with `rst=1` → x5 stays 0.
- Signed arithmetic: x1=5 via ADDI, `SUB x2,x0,x1` → x2=0xFFFFFFFB. `SRAI x3,x2,1` → 0xFFFFFFFD. `SRLI x4,x2,28` → 0xF.
- Compares: `ADDI x1,x0,-1`. `SLT x2,x1,x0` → 1. `SLTU x3,x1,x0` → 0. `SLTIU x4,x0,-1` → 1.
- x0 and NOP:
  - `ADDI x0,x0,99` → x0 reads 0.
  - Opcode `1111111` with rd=5 → x5 unchanged.
  - `LUI x6,0xABCDE` → x6=0xABCDE000.
- Logic and shifts: x1=0x0F0 via ADDI. `XORI x2,x1,0x0FF` → 0x00F. `ORI`/`ANDI` with 0x00F → 0x0FF / 0. `SLLI x3,x1,4` → 0xF00.
